// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer.
package piso_pkg;

  typedef enum logic {IDLE, SHIFT} state_e;

  function automatic int unsigned cnt_w(input int unsigned frame);
    return $clog2(frame + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable up-counter tracking the bit position within a serial frame.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int unsigned MAX = 4,
  localparam int unsigned CW = cnt_w(MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          at_max
);

  // Load wins over clear so a back-to-back accept restarts the frame at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(1);
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + CW'(1);
    end
  end

  assign at_max = (count == CW'(MAX));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage with valid/ready input and valid/last serial output.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned CW = cnt_w(FRAME);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, src;
  logic             ser_out_d, ser_valid_d;
  logic [CW-1:0]    count;
  logic             at_max, accept, shifting, clr;
`ifdef PISO_PARITY_EN
  logic             parity_q;
`endif

  piso_bit_counter #(
    .MAX(FRAME)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .inc   (shifting),
    .clr   (clr),
    .count (count),
    .at_max(at_max)
  );

  assign in_ready = ~rst & ((state_q == IDLE) | ((state_q == SHIFT) & at_max));
  assign accept   = in_valid & in_ready;
  assign shifting = (state_q == SHIFT) & (count < CW'(FRAME));

  // The register holds the bits still to be sent; the presented bit lives in ser_out.
  always_comb begin
    state_d     = state_q;
    src         = sreg_q;
    sreg_d      = sreg_q;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    clr         = 1'b0;
    if (accept) begin
      state_d     = SHIFT;
      src         = in;
      ser_valid_d = 1'b1;
    end else if (shifting) begin
      ser_valid_d = 1'b1;
    end else if (state_q == SHIFT) begin
      state_d = IDLE;
      clr     = 1'b1;
    end
    if (ser_valid_d) begin
      ser_out_d = MSB_FIRST ? src[WIDTH-1] : src[0];
      sreg_d    = MSB_FIRST ? (src << 1) : (src >> 1);
    end
`ifdef PISO_PARITY_EN
    if (shifting && count == CW'(WIDTH)) begin
      ser_out_d = parity_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      ser_out   <= ser_out_d;
      ser_valid <= ser_valid_d;
    end
  end

`ifdef PISO_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^in;
    end
  end
`endif

  assign ser_last = at_max;
  assign busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances against a queue-based model.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_word = '0;

  logic rdy_m, out_m, val_m, last_m, busy_m;
  logic rdy_l, out_l, val_l, last_l, busy_l;

  int n_checks = 0;
  int n_fail   = 0;

  // Bits still to appear on each serial stream; element 0 is the one on the wire now.
  bit qm[$];
  bit ql[$];
  bit acc = 1'b0;

  piso_serializer #(
    .WIDTH    (W),
    .MSB_FIRST(1'b1)
  ) dut_m (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (rdy_m),
    .in       (in_word),
    .ser_out  (out_m),
    .ser_valid(val_m),
    .ser_last (last_m),
    .busy     (busy_m)
  );

  piso_serializer #(
    .WIDTH    (W),
    .MSB_FIRST(1'b0)
  ) dut_l (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (rdy_l),
    .in       (in_word),
    .ser_out  (out_l),
    .ser_valid(val_l),
    .ser_last (last_l),
    .busy     (busy_l)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_ready();
    return !rst && (qm.size() <= 1);
  endfunction

  task automatic check_outputs();
    check_eq("in_ready_msb", rdy_m, exp_ready());
    check_eq("in_ready_lsb", rdy_l, exp_ready());
    check_eq("ser_valid_msb", val_m, qm.size() != 0);
    check_eq("ser_valid_lsb", val_l, ql.size() != 0);
    check_eq("ser_out_msb", out_m, (qm.size() != 0) ? qm[0] : 1'b0);
    check_eq("ser_out_lsb", out_l, (ql.size() != 0) ? ql[0] : 1'b0);
    check_eq("ser_last_msb", last_m, qm.size() == 1);
    check_eq("ser_last_lsb", last_l, ql.size() == 1);
    check_eq("busy_msb", busy_m, qm.size() != 0);
    check_eq("busy_lsb", busy_l, ql.size() != 0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_ready_msb", rdy_m, 1'b0);
    check_eq("rst_ready_lsb", rdy_l, 1'b0);
    check_eq("rst_valid_msb", val_m, 1'b0);
    check_eq("rst_valid_lsb", val_l, 1'b0);
    check_eq("rst_out_msb", out_m, 1'b0);
    check_eq("rst_out_lsb", out_l, 1'b0);
    check_eq("rst_last_msb", last_m, 1'b0);
    check_eq("rst_last_lsb", last_l, 1'b0);
    check_eq("rst_busy_msb", busy_m, 1'b0);
    check_eq("rst_busy_lsb", busy_l, 1'b0);
  endtask

  task automatic push_frame(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      qm.push_back(w[W-1-i]);
      ql.push_back(w[i]);
    end
`ifdef PISO_PARITY_EN
    qm.push_back(^w);
    ql.push_back(^w);
`endif
  endtask

  // One clock: check at the falling edge, then advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    acc = in_valid && exp_ready();
    @(posedge clk);
    if (rst) begin
      qm.delete();
      ql.delete();
    end else begin
      if (qm.size() != 0) void'(qm.pop_front());
      if (ql.size() != 0) void'(ql.pop_front());
      if (acc) push_frame(in_word);
    end
    #1;
  endtask

  // Present a word and hold it until the model says it was taken.
  task automatic send(input logic [W-1:0] w);
    in_valid = 1'b1;
    in_word  = w;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      step();
      if (acc) break;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no accept, expected accept of %b", w);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset held, with in_valid asserted to show it is ignored.
    in_valid = 1'b1;
    in_word  = 4'b1111;
    step();
    step();
    rst = 1'b0;
    in_valid = 1'b0;

    send(4'b1011);
    idle(FRAME + 2);

    send(4'b1011);
    send(4'b1110);
    idle(FRAME + 2);

    send(4'b1011);
    in_valid = 1'b0;
    step();
    send(4'b0101);
    idle(FRAME + 2);

    send(4'b0000);
    idle(FRAME + 1);

    // Asynchronous reset in the middle of a frame.
    send(4'b1001);
    in_valid = 1'b0;
    step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    qm.delete();
    ql.delete();
    in_valid = 1'b1;
    in_word  = 4'b0101;
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    send(4'b1110);
    idle(FRAME + 2);

    // Random traffic; a presented word is held until taken.
    for (int c = 0; c < 600; c++) begin
      if (!(in_valid && !acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_word  = W'($urandom);
      end
      step();
    end
    idle(FRAME + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
